// File: rtl/port_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : port_tx_pkg
// Brief    : Constants, control-word layout and FSM type shared by the switch
//            port blocks (ingress, egress, queue manager).
// Revision : 1.0 - initial release
// ============================================================================
package port_tx_pkg;

    localparam int DATA_W   = 16;
    localparam int PRIO_N   = 8;
    localparam int PRIO_W   = 3;
    localparam int LEN_W    = 9;
    localparam int CNT_W    = 9;

    // Control-word field offsets
    localparam int DEST_LSB = 0;
    localparam int DEST_MSB = 3;
    localparam int PRIO_LSB = 4;
    localparam int PRIO_MSB = 6;
    localparam int LEN_LSB  = 7;
    localparam int LEN_MSB  = 15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOP  = 3'd1,
        ST_HEAD = 3'd2,
        ST_BODY = 3'd3,
        ST_EOP  = 3'd4
    } tx_state_e;

    // Byte length to 16-bit word count; one bit wider so L=511 yields 256.
    function automatic logic [LEN_W:0] words_from_len(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] w_sum;
        w_sum = {1'b0, len} + (LEN_W+1)'(1);
        return w_sum >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/port_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : port_tx_if
// Brief    : Egress port bundle: external rd_* packet stream plus the
//            priority-queue pop interface.
// Revision : 1.0 - initial release
// ============================================================================
interface port_tx_if;
    import port_tx_pkg::*;

    logic                ready;
    logic                rd_sop;
    logic                rd_vld;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_eop;
    logic                busy;
    logic [PRIO_N-1:0]   q_nonempty;
    logic                q_rd_en;
    logic [PRIO_W-1:0]   q_rd_prior;
    logic [DATA_W-1:0]   q_data;

    modport master (
        input  ready, q_nonempty, q_data,
        output rd_sop, rd_vld, rd_data, rd_eop, busy, q_rd_en, q_rd_prior
    );

    modport slave (
        output ready, q_nonempty, q_data,
        input  rd_sop, rd_vld, rd_data, rd_eop, busy, q_rd_en, q_rd_prior
    );

endinterface
`default_nettype wire

// File: rtl/port_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : port_tx_arb
// Brief    : Queue winner select. Strict priority (highest index) by default;
//            round-robin with a last-served pointer when PORT_TX_RR_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module port_tx_arb
    import port_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PRIO_N-1:0] i_q_nonempty,
    input  logic              i_take,
    output logic [PRIO_W-1:0] o_winner
);

`ifdef PORT_TX_RR_EN
    logic [PRIO_W-1:0] r_ptr;
    logic [PRIO_W-1:0] w_idx;
    logic              w_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= PRIO_W'(PRIO_N - 1);
        end else if (i_take) begin
            r_ptr <= o_winner;
        end
    end

    // Scan upward from ptr+1; the 3-bit add wraps modulo 8, ptr itself last.
    always_comb begin
        o_winner = r_ptr;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 1; i <= PRIO_N; i++) begin
            w_idx = r_ptr + PRIO_W'(i);
            if (!w_found && i_q_nonempty[w_idx]) begin
                o_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end
`else
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, clk, rst, i_take};

    always_comb begin
        o_winner = '0;
        for (int i = 0; i < PRIO_N; i++) begin
            if (i_q_nonempty[i]) begin
                o_winner = PRIO_W'(i);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/port_tx.sv
`default_nettype none
// ============================================================================
// Module   : port_tx
// Brief    : Switch egress port. Pops one packet from the winning priority
//            queue and streams it as sop / control word / body / eop.
// Config   : PORT_TX_RR_EN - round-robin queue arbitration (default strict).
// Revision : 1.0 - initial release
// ============================================================================
module port_tx
    import port_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    port_tx_if.master   bus
);

    tx_state_e          r_state;
    tx_state_e          w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [PRIO_W-1:0]  r_prior;
    logic [PRIO_W-1:0]  w_winner;
    logic               r_pop_q;
    logic               r_vld;
    logic               r_eop;
    logic [DATA_W-1:0]  r_data;
    logic               w_pop;
    logic               w_take;
    logic [LEN_W:0]     w_n;

    port_tx_arb u_arb (
        .clk          (clk),
        .rst          (rst),
        .i_q_nonempty (bus.q_nonempty),
        .i_take       (w_take),
        .o_winner     (w_winner)
    );

    assign w_n = words_from_len(bus.q_data[LEN_MSB:LEN_LSB]);

    // r_cnt holds body pops still to issue after the current one.
    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        w_pop     = 1'b0;
        w_take    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.ready && (|bus.q_nonempty)) begin
                    w_take = 1'b1;
                    w_next = ST_SOP;
                end
            end
            ST_SOP: begin
                w_pop  = 1'b1;
                w_next = ST_HEAD;
            end
            ST_HEAD: begin
                if (w_n == '0) begin
                    w_next = ST_EOP;
                end else begin
                    w_pop = 1'b1;
                    if (w_n == (LEN_W+1)'(1)) begin
                        w_next = ST_EOP;
                    end else begin
                        w_cnt_nxt = CNT_W'(w_n - (LEN_W+1)'(1));
                        w_next    = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                w_pop = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_next = ST_EOP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_EOP: begin
                // Leave once the final pop's data has been taken off q_data.
                if (!r_pop_q) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_prior <= '0;
            r_pop_q <= 1'b0;
            r_vld   <= 1'b0;
            r_data  <= '0;
            r_eop   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            if (w_take) begin
                r_prior <= w_winner;
            end
            r_pop_q <= w_pop;
            r_vld   <= r_pop_q;
            r_data  <= r_pop_q ? bus.q_data : '0;
            r_eop   <= (r_state == ST_EOP) && !r_pop_q;
        end
    end

    assign bus.rd_sop     = (r_state == ST_SOP);
    assign bus.rd_vld     = r_vld;
    assign bus.rd_data    = r_data;
    assign bus.rd_eop     = r_eop;
    assign bus.busy       = (r_state != ST_IDLE) || r_eop;
    assign bus.q_rd_en    = w_pop;
    assign bus.q_rd_prior = r_prior;

endmodule
`default_nettype wire

// File: tb/tb_port_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_tx
// Brief    : Self-checking bench for port_tx: queue model feeding q_data and a
//            scoreboard of expected words, priorities and packet timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_port_tx;
    import port_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;

    port_tx_if bus();

    port_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [15:0] mq [0:7][$];
    logic [15:0] exp_word [$];
    int          exp_prio [$];
    int          exp_n    [$];

`ifdef PORT_TX_RR_EN
    logic [2:0] m_ptr = 3'd7;
`endif

    function automatic logic [2:0] arb_model(input logic [7:0] ne);
        logic [2:0] w;
        bit         found;
        w     = 3'd0;
        found = 1'b0;
`ifdef PORT_TX_RR_EN
        for (int i = 1; i <= 8; i++) begin
            logic [2:0] j;
            j = m_ptr + 3'(i);
            if (!found && ne[j]) begin
                w     = j;
                found = 1'b1;
            end
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (!found && ne[i]) begin
                w     = 3'(i);
                found = 1'b1;
            end
        end
`endif
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue model: data for a pop appears the cycle after q_rd_en.
    initial begin
        logic       en_s;
        logic [2:0] pr_s;
        forever begin
            @(negedge clk);
            en_s = bus.q_rd_en;
            pr_s = bus.q_rd_prior;
            @(posedge clk);
            #1;
            if (en_s && mq[pr_s].size() > 0) bus.q_data = mq[pr_s].pop_front();
            else                             bus.q_data = '0;
        end
    end

    // Output monitor and scoreboard
    initial begin
        int          cyc;
        int          t0;
        int          vk;
        int          en_cnt;
        int          cur_n;
        int          cur_prio;
        int          nact;
        bit          in_pkt;
        logic [15:0] ew;
        cyc = 0; t0 = 0; vk = 0; en_cnt = 0; cur_n = 0; cur_prio = 0; in_pkt = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst || abort) begin
                in_pkt = 1'b0;
                continue;
            end
            if (bus.rd_sop) begin
                if (exp_prio.size() == 0) begin
                    chk("sop_unexpected", 1, 0);
                end else begin
                    cur_prio = exp_prio.pop_front();
                    cur_n    = exp_n.pop_front();
                    chk("sop_prior", 32'(bus.q_rd_prior), cur_prio);
                end
                in_pkt = 1'b1; t0 = cyc; vk = 0; en_cnt = 0;
            end
            nact = int'(bus.rd_sop) + int'(bus.rd_vld) + int'(bus.rd_eop);
            chk("sop_vld_eop_exclusive", 32'(nact > 1), 0);
            chk("busy", 32'(bus.busy), 32'(in_pkt));
            if (bus.q_rd_en) begin
                en_cnt++;
                chk("rd_en_prior", 32'(bus.q_rd_prior), cur_prio);
                chk("rd_en_in_packet", 32'(in_pkt), 1);
            end
            if (bus.rd_vld) begin
                chk("vld_cycle", cyc, t0 + 2 + vk);
                if (exp_word.size() == 0) begin
                    chk("word_unexpected", 1, 0);
                end else begin
                    ew = exp_word.pop_front();
                    chk("rd_data", 32'(bus.rd_data), 32'(ew));
                end
                vk++;
            end else begin
                chk("rd_data_idle_zero", 32'(bus.rd_data), 0);
            end
            if (bus.rd_eop) begin
                chk("eop_cycle", cyc, t0 + 3 + cur_n);
                chk("word_count", vk, cur_n + 1);
                chk("rd_en_count", en_cnt, cur_n + 1);
                in_pkt = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst   = 1'b1;
        abort = 1'b1;
        tick();
        chk("rst_sop",   32'(bus.rd_sop), 0);
        chk("rst_vld",   32'(bus.rd_vld), 0);
        chk("rst_data",  32'(bus.rd_data), 0);
        chk("rst_eop",   32'(bus.rd_eop), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_rd_en", 32'(bus.q_rd_en), 0);
        chk("rst_prior", 32'(bus.q_rd_prior), 0);
        chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        rst = 1'b0;
        bus.ready      = 1'b0;
        bus.q_nonempty = '0;
        for (int p = 0; p < 8; p++) mq[p].delete();
        exp_word.delete();
        exp_prio.delete();
        exp_n.delete();
`ifdef PORT_TX_RR_EN
        m_ptr = 3'd7;
`endif
        repeat (5) begin
            tick();
            chk("post_rst_no_eop", 32'(bus.rd_eop), 0);
            chk("post_rst_no_vld", 32'(bus.rd_vld), 0);
        end
        abort = 1'b0;
    endtask

    // Preload 'count' packets per the arbitration model, then release ready.
    task automatic run_burst(input logic [7:0] ne, input int count, input logic [8:0] len,
                             input int idle_cyc, input bit disturb, input int abort_at);
        logic [2:0]  p;
        logic [15:0] w;
        int          nw;
        int          waited;
        int          sops;
        int          eops;
        int          since;
        int          budget;
        nw = int'(words_from_len(len));
        for (int k = 0; k < count; k++) begin
            p = arb_model(ne);
`ifdef PORT_TX_RR_EN
            m_ptr = p;
`endif
            w = {len, p, 4'(k)};
            mq[p].push_back(w);
            exp_word.push_back(w);
            for (int b = 0; b < nw; b++) begin
                w = 16'($urandom);
                mq[p].push_back(w);
                exp_word.push_back(w);
            end
            exp_prio.push_back(int'(p));
            exp_n.push_back(nw);
        end
        bus.q_nonempty = ne;
        for (int c = 0; c < idle_cyc; c++) begin
            tick();
            chk("idle_no_sop",   32'(bus.rd_sop), 0);
            chk("idle_no_rd_en", 32'(bus.q_rd_en), 0);
        end
        bus.ready = 1'b1;
        waited = 0;
        while (!bus.rd_sop && waited < 50) begin
            tick();
            waited++;
        end
        chk("sop_latency", waited, 1);
        if (!bus.rd_sop) begin
            bus.ready = 1'b0;
            bus.q_nonempty = '0;
            return;
        end
        sops = 1; eops = 0; since = 0;
        if (sops == count) begin
            bus.ready = 1'b0;
            bus.q_nonempty = '0;
        end
        budget = count * (nw + 10) + 20;
        while (eops < count && budget > 0) begin
            if (abort_at > 0 && since >= abort_at) begin
                do_reset();
                return;
            end
            tick();
            budget--;
            since++;
            if (bus.rd_sop) begin
                sops++;
                if (sops == count) begin
                    bus.ready = 1'b0;
                    bus.q_nonempty = '0;
                end
            end
            if (bus.rd_eop) eops++;
            if (disturb && since == 10) begin
                bus.ready = 1'b1;
                bus.q_nonempty = 8'h5A;
            end
            if (disturb && since == 20) begin
                bus.ready = 1'b0;
                bus.q_nonempty = '0;
            end
        end
        chk("eop_seen", eops, count);
        chk("scoreboard_drained", exp_word.size(), 0);
    endtask

    initial begin
        bus.ready      = 1'b0;
        bus.q_nonempty = '0;
        bus.q_data     = '0;
        rst            = 1'b1;
        repeat (3) tick();
        chk("reset_sop",   32'(bus.rd_sop), 0);
        chk("reset_vld",   32'(bus.rd_vld), 0);
        chk("reset_data",  32'(bus.rd_data), 0);
        chk("reset_eop",   32'(bus.rd_eop), 0);
        chk("reset_busy",  32'(bus.busy), 0);
        chk("reset_rd_en", 32'(bus.q_rd_en), 0);
        chk("reset_prior", 32'(bus.q_rd_prior), 0);
        rst = 1'b0;
        tick();

        run_burst(8'h24, 1, 9'd5,   0,  1'b0, 0);
        run_burst(8'h08, 1, 9'd0,   0,  1'b0, 0);
        run_burst(8'hFF, 1, 9'd7,   20, 1'b0, 0);
        run_burst(8'h02, 1, 9'd511, 0,  1'b1, 0);
        run_burst(8'h40, 2, 9'd1,   0,  1'b0, 0);
        run_burst(8'h40, 1, 9'd2,   0,  1'b0, 0);
        run_burst(8'h10, 1, 9'd40,  0,  1'b0, 6);
        run_burst(8'h81, 4, 9'd3,   0,  1'b0, 0);
        run_burst(8'h20, 1, 9'd6,   0,  1'b0, 0);

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
